// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
package serial_add_pkg;

    localparam int unsigned DEFAULT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit counter must hold values 0..w, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 1) ? 1 : $clog2(w + 1);
    endfunction

endpackage

// File: rtl/piso_shreg.sv
// Parallel-load, shift-right register presenting its LSB as the serial output.
module piso_shreg
    import serial_add_pkg::*;
#(
    parameter int unsigned W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         sout
);

    logic [W-1:0] q;

    always_ff @(posedge clk) begin : shreg
        if (!rstn) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= q >> 1;
        end
    end

    assign sout = q[0];

endmodule

// File: rtl/serial_adder_seq.sv
// Bit-serial sequencer feeding an external full_adder, LSB first, one bit per cycle.
// Optional signed-overflow output compiled in with SERIAL_ADDER_OVF_EN.
module serial_adder_seq
    import serial_add_pkg::*;
#(
    parameter int unsigned W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         cin,
    output logic         fa_a,
    output logic         fa_b,
    output logic         fa_cin,
    input  logic         fa_sum,
    input  logic         fa_cout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int unsigned CW = cnt_width(W);

    state_e        state;
    state_e        state_nxt;
    logic [CW-1:0] cnt;
    logic          carry_q;
    logic [W-1:0]  sum_sh;
    logic [W-1:0]  sum_shifted;
    logic          a_bit;
    logic          b_bit;
    logic          accept;
    logic          running;
    logic          last_bit;

    assign accept      = in_valid && (state == IDLE);
    assign running     = (state == RUN);
    assign last_bit    = running && (cnt == CW'(W - 1));
    assign sum_shifted = W'({fa_sum, sum_sh} >> 1);

    piso_shreg #(.W(W)) u_sh_a (
        .clk   (clk),
        .rstn  (rstn),
        .load  (accept),
        .shift (running),
        .din   (op_a),
        .sout  (a_bit)
    );

    piso_shreg #(.W(W)) u_sh_b (
        .clk   (clk),
        .rstn  (rstn),
        .load  (accept),
        .shift (running),
        .din   (op_b),
        .sout  (b_bit)
    );

    always_ff @(posedge clk) begin : state_reg
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin : next_state
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last_bit)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin : out_dec
        in_ready  = 1'b0;
        out_valid = 1'b0;
        fa_a      = 1'b0;
        fa_b      = 1'b0;
        fa_cin    = 1'b0;
        unique case (state)
            IDLE: in_ready = 1'b1;
            RUN: begin
                fa_a   = a_bit;
                fa_b   = b_bit;
                fa_cin = carry_q;
            end
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Carry recirculation, result SIPO and the held result registers.
    always_ff @(posedge clk) begin : datapath
        if (!rstn) begin
            cnt     <= '0;
            carry_q <= 1'b0;
            sum_sh  <= '0;
            sum     <= '0;
            cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            if (accept) begin
                cnt     <= '0;
                carry_q <= cin;
            end else if (running) begin
                cnt     <= cnt + CW'(1);
                carry_q <= fa_cout;
                sum_sh  <= sum_shifted;
            end
            if (last_bit) begin
                sum  <= sum_shifted;
                cout <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                // Carry into MSB differs from carry out of MSB on signed overflow.
                ovf  <= carry_q ^ fa_cout;
`endif
            end
        end
    end

endmodule
